branch_seq: RTL

- Consumer side of the zero-flag register in the RISC-SPM datapath. It reads the registered zero flag and sequences the branch instructions BR and BRZ.
- For a taken branch it fetches the target byte from memory and loads it into the PC. For a not-taken branch it skips the address byte.
- Sits between the control unit (start/done handshake) and the PC/memory datapath.

---
 rtl/branch_seq.sv | 114 +++++++++++
 1 files changed

// File: rtl/branch_seq.sv
// branch_seq: sequences BR/BRZ (and BRNZ when BRNZ_EN is defined) against the registered zero flag.
// Latency: start->done is 2 cycles for a taken branch, 1 cycle for not-taken or illegal.
// Backpressure: none; start is accepted only in IDLE, and a start seen while busy is dropped.
module branch_seq #(
   parameter int                  WORD_SIZE = 8,
   parameter int                  OP_SIZE   = 4,
   parameter logic [OP_SIZE-1:0]  OP_BR     = 4'b0111,
   parameter logic [OP_SIZE-1:0]  OP_BRZ    = 4'b1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [OP_SIZE-1:0]    opcode,
   input  logic                  zero,
   input  logic [WORD_SIZE-1:0]  pc_in,
   input  logic [WORD_SIZE-1:0]  mem_data,
   output logic [WORD_SIZE-1:0]  mem_addr,
   output logic                  mem_rd,
   output logic [WORD_SIZE-1:0]  pc_out,
   output logic                  pc_load,
   output logic                  pc_inc,
   output logic                  busy,
   output logic                  done,
   output logic                  taken,
   output logic                  illegal
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_FETCH = 1'b1;

`ifdef BRNZ_EN
   localparam logic [OP_SIZE-1:0] OP_BRNZ = OP_SIZE'(4'b1001);
`endif

   logic [0:0] state;
   logic       is_cond;      // recognised conditional branch opcode
   logic       take_branch;  // branch resolves taken with the zero flag seen this cycle

   // Decode the opcode and the live zero flag; only used on the edge that accepts start,
   // so the flag is effectively captured at that edge and later changes do not matter.
   always_comb begin
      is_cond     = 1'b0;
      take_branch = 1'b0;
      if (opcode == OP_BR) begin
         take_branch = 1'b1;
      end else if (opcode == OP_BRZ) begin
         is_cond     = 1'b1;
         take_branch = zero;
      end
`ifdef BRNZ_EN
      else if (opcode == OP_BRNZ) begin
         is_cond     = 1'b1;
         take_branch = ~zero;
      end
`endif
   end

   // Two-state sequencer; every output is a register, and pulses clear unless set this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         mem_addr <= '0;
         pc_out   <= '0;
         mem_rd   <= 1'b0;
         pc_load  <= 1'b0;
         pc_inc   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         taken    <= 1'b0;
         illegal  <= 1'b0;
      end else begin
         mem_rd  <= 1'b0;
         pc_load <= 1'b0;
         pc_inc  <= 1'b0;
         done    <= 1'b0;
         taken   <= 1'b0;
         illegal <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (take_branch) begin
                     // Taken: read the address byte the PC points at.
                     state    <= S_FETCH;
                     mem_addr <= pc_in;
                     mem_rd   <= 1'b1;
                     busy     <= 1'b1;
                  end else if (is_cond) begin
                     // Not taken: step the PC over the address byte.
                     pc_inc <= 1'b1;
                     done   <= 1'b1;
                  end else begin
                     done    <= 1'b1;
                     illegal <= 1'b1;
                  end
               end
            end
            S_FETCH: begin
               // Memory is combinational, so the target is on mem_data now.
               pc_out  <= mem_data;
               pc_load <= 1'b1;
               done    <= 1'b1;
               taken   <= 1'b1;
               busy    <= 1'b0;
               state   <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
